// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
// Multicycle control unit for the 32-bit MIPS-subset datapath. Sequences
// fetch / decode / execute / memory / writeback, drives every datapath enable
// and the 6-bit ALU operation code, and resolves branches from the ALU zero flag.
// Memory accesses stall on mem_ready_i.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset (forces FETCH)
//   opcode_i       IR[31:26], stable from DECODE until the next FETCH
//   funct_i        IR[5:0]
//   zero_i         ALU zero flag
//   mem_ready_i    memory access completes this cycle
//   alu_control_o  ALU operation select
//   alu_src_a_o    0=PC, 1=rs
//   alu_src_b_o    00=rt, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
//   iord_o         memory address select: 0=PC, 1=ALUOut
//   mem_read_o     memory read request
//   mem_write_o    memory write request
//   ir_write_o     instruction register load
//   pc_write_o     PC load
//   pc_source_o    00=ALU result, 01=ALUOut, 10=jump target
//   reg_write_o    register file write enable
//   reg_dst_o      0=rt, 1=rd
//   mem_to_reg_o   0=ALUOut, 1=MDR
//   illegal_op_o   one-cycle pulse on an unsupported instruction
//   state_o        current state code (debug)
// -----------------------------------------------------------------------------
module mc_control_fsm #(
    parameter logic [5:0] ALU_ADD = 6'b100001,
    parameter logic [5:0] ALU_SUB = 6'b100011,
    parameter logic [5:0] ALU_NE  = 6'b111101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic [5:0] alu_control_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic [1:0] pc_source_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       illegal_op_o,
    output logic [3:0] state_o
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        IEXEC   = 4'd10,
        IWB     = 4'd11,
        ILLEGAL = 4'd12
    } state_t;

    state_t state_q, state_d;
    logic   functOk;

    // R-type instructions are only accepted for the supported funct codes
    // (addu, subu, and, or, sltu); anything else traps.
    always_comb begin
        functOk = 1'b0;
        case (funct_i)
            6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101011: functOk = 1'b1;
            default: functOk = 1'b0;
        endcase
    end

    // State register: reset drops any in-flight instruction and restarts fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode. All enables default low, ALU defaults to add.
    always_comb begin
        state_d       = state_q;
        alu_control_o = ALU_ADD;
        alu_src_a_o   = 1'b0;
        alu_src_b_o   = 2'b00;
        iord_o        = 1'b0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        ir_write_o    = 1'b0;
        pc_write_o    = 1'b0;
        pc_source_o   = 2'b00;
        reg_write_o   = 1'b0;
        reg_dst_o     = 1'b0;
        mem_to_reg_o  = 1'b0;
        illegal_op_o  = 1'b0;

        case (state_q)
            FETCH: begin
                // IR and PC+4 are latched in the same cycle the read completes.
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                if (mem_ready_i) state_d = DECODE;
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded.
                alu_src_b_o = 2'b11;
                case (opcode_i)
                    OP_RTYPE:      state_d = functOk ? EXEC : ILLEGAL;
                    OP_LW, OP_SW:  state_d = MEMADR;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_J:          state_d = JUMP;
                    OP_ADDIU:      state_d = IEXEC;
                    default:       state_d = ILLEGAL;
                endcase
            end
            MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d     = (opcode_i == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                if (mem_ready_i) state_d = MEMWB;
            end
            MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                state_d      = FETCH;
            end
            MEMWR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
                if (mem_ready_i) state_d = FETCH;
            end
            EXEC: begin
                alu_src_a_o   = 1'b1;
                alu_control_o = funct_i;
                state_d       = ALUWB;
            end
            ALUWB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                // bne uses the not-equal ALU op, so zero=1 means taken for both.
                alu_src_a_o   = 1'b1;
                alu_control_o = (opcode_i == OP_BNE) ? ALU_NE : ALU_SUB;
                pc_source_o   = 2'b01;
                pc_write_o    = zero_i;
                state_d       = FETCH;
            end
            JUMP: begin
                pc_source_o = 2'b10;
                pc_write_o  = 1'b1;
                state_d     = FETCH;
            end
            IEXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d     = IWB;
            end
            IWB: begin
                reg_write_o = 1'b1;
                state_d     = FETCH;
            end
            ILLEGAL: begin
                // PC was already advanced in FETCH, so just flag and move on.
                illegal_op_o = 1'b1;
                state_d      = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign state_o = state_q;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multicycle control unit for the 32-bit MIPS-subset datapath. It is the producing end of the ALU's alu_control/zero interface: it decodes the latched instruction, sequences fetch/decode/execute/memory/writeback, drives every datapath enable and the 6-bit ALU operation code, and consumes the ALU zero flag for branch resolution. A ready handshake stalls it on memory access.

Parameters:
ALU_ADD, 6'b100001, ALU code for add (addu, addiu, address calc, PC+4)
ALU_SUB, 6'b100011, ALU code for subtract (subu, beq compare)
ALU_NE, 6'b111101, ALU code for not-equal compare (bne; result 0 when a!=b)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
opcode  in  6  IR[31:26], stable from DECODE until FETCH
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag (result==0)
mem_ready  in  1  memory access complete this cycle
alu_control  out  6  ALU operation select
alu_src_a  out  1  0=PC, 1=rs register
alu_src_b  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
iord  out  1  memory address: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  latch instruction register
pc_write  out  1  load PC
pc_source  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target
reg_write  out  1  register file write enable
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
illegal_op  out  1  one-cycle pulse on unsupported instruction
state  out  4  current state code (debug)

Behaviour:
- State register only sequential element; rst asserted (any time, mid-instruction included) forces FETCH immediately; no pending write survives reset.
- Outputs combinational from state (plus mem_ready/zero where stated); unlisted outputs 0 in every state; alu_control defaults to ALU_ADD.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, ILLEGAL=12.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=ALU_ADD, pc_source=00; ir_write=pc_write=mem_ready. Stay until mem_ready, then DECODE. During reset outputs equal FETCH values (ir_write/pc_write follow mem_ready but have no effect under reset).
- DECODE: alu_src_a=0, alu_src_b=11, ALU_ADD (branch target). Next by opcode: 000000->EXEC if funct in {100001,100011,100100,100101,101011} else ILLEGAL; 100011(lw)/101011(sw)->MEMADR; 000100(beq)/000101(bne)->BRANCH; 000010(j)->JUMP; 001001(addiu)->IEXEC; other->ILLEGAL.
- EXEC: alu_src_a=1, alu_src_b=00, alu_control=funct. ->ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. ->FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, ALU_ADD. ->MEMRD if lw, MEMWR if sw.
- MEMRD: mem_read=1, iord=1; wait for mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. ->FETCH.
- MEMWR: mem_write=1, iord=1; held until mem_ready, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_control=ALU_SUB (beq) or ALU_NE (bne), pc_source=01, pc_write=zero (taken in both cases when zero=1). ->FETCH.
- JUMP: pc_source=10, pc_write=1. ->FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10, ALU_ADD. ->IWB. IWB: reg_write=1, reg_dst=0, mem_to_reg=0. ->FETCH.
- ILLEGAL: illegal_op=1 for exactly one cycle, no writes, PC already advanced; ->FETCH.
- Latency with mem_ready tied 1: R-type 4, addiu 4, lw 5, sw 4, branch 3, j 3 cycles. Each cycle of mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle.
- Never mem_read and mem_write together; reg_write only in ALUWB/MEMWB/IWB.

Test Plan:
- Reset: rst=1 mid-MEMWR (mem_write=1) -> same-cycle state=0, mem_write=0, mem_read=1, alu_control=100001; release -> FETCH.
- R-type: mem_ready=1, opcode=0, funct=100100 -> states 0,1,6,7,0; alu_control=100100 in EXEC; reg_write=1, reg_dst=1 only in ALUWB.
- lw with stall: opcode=100011, mem_ready low 2 cycles in MEMRD -> 7 cycles total; iord=1 throughout MEMRD; mem_to_reg=1 in MEMWB.
- bne: opcode=000101, zero=1 -> alu_control=111101, pc_write=1, pc_source=01; repeat zero=0 -> pc_write=0; beq uses 100011 with same zero rule.
- j and addiu: opcode=000010 -> pc_source=10, pc_write=1, 3 cycles; opcode=001001 -> alu_src_b=10, reg_dst=0 write in IWB.
- Illegal: opcode=111111, then opcode=0 funct=000000 -> ILLEGAL, illegal_op high exactly one cycle, no reg_write/mem_write, back to FETCH.
